shift_iter_unit: RTL

//   Multi-cycle 32-bit shifter for the ALU shift path. Applies the fixed
//   16/8/4/2/1-bit shift stages one per clock, selected by the bits of the

---
 rtl/shift_pkg.sv | 19 +
 rtl/shift_stage_sel.sv | 27 ++
 rtl/shift_iter_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shifter: op codes, FSM states and sizing constants.
package shift_pkg;

    localparam int AMT_W = 5;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRA  = 2'b01,
        OP_SRL  = 2'b10,
        OP_RSVD = 2'b11
    } shift_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shift_state_e;

endpackage

// File: rtl/shift_stage_sel.sv
// One shift stage: shifts by 2^idx in the direction and fill of the op.
// The reserved op passes the input through untouched.
module shift_stage_sel
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_in,
    input  logic [IDX_W-1:0] i_idx,
    input  shift_op_e        i_op,
    output logic [WIDTH-1:0] o_out
);

    logic [AMT_W-1:0] w_dist;

    always_comb begin
        w_dist = AMT_W'(1) << i_idx;
        o_out  = i_in;
        case (i_op)
            OP_SLL:  o_out = i_in << w_dist;
            OP_SRA:  o_out = $unsigned($signed(i_in) >>> w_dist);
            OP_SRL:  o_out = i_in >> w_dist;
            default: o_out = i_in;
        endcase
    end

endmodule

// File: rtl/shift_iter_unit.sv
// Multi-cycle shifter: one fixed 16/8/4/2/1 stage per clock, constant 5-edge latency,
// start pulse in and one-cycle ready pulse out like the mult/div unit.
module shift_iter_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ctrl_shift,
    input  logic [1:0]       ctrl_shiftop,
    input  logic [AMT_W-1:0] ctrl_shiftamt,
    input  logic [WIDTH-1:0] data_operandA,
    output logic [WIDTH-1:0] data_result,
    output logic             data_resultRDY,
    output logic             data_exception,
    output logic             busy
);

    shift_state_e     r_state;
    shift_state_e     w_stateNext;
    shift_op_e        r_op;
    logic [AMT_W-1:0] r_amt;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_rdy;
    logic             r_exc;
    logic             w_start;
    logic             w_done;
    logic [WIDTH-1:0] w_stageOut;
    logic [WIDTH-1:0] w_accNext;

    shift_stage_sel #(.WIDTH(WIDTH)) u_stage (
        .i_in  (r_acc),
        .i_idx (r_idx),
        .i_op  (r_op),
        .o_out (w_stageOut)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ctrl_shift) begin
                    w_start     = 1'b1;
                    w_stateNext = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_idx == '0) begin
                    w_done      = 1'b1;
                    w_stateNext = ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    assign w_accNext = r_amt[r_idx] ? w_stageOut : r_acc;

    // The final stage result goes straight to the output register, skipping r_acc.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_op     <= OP_SLL;
            r_amt    <= '0;
            r_idx    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_rdy    <= 1'b0;
            r_exc    <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (w_start) begin
                r_acc <= data_operandA;
                r_amt <= ctrl_shiftamt;
                r_op  <= shift_op_e'(ctrl_shiftop);
                r_idx <= IDX_W'(AMT_W - 1);
                r_exc <= 1'b0;
            end else if (r_state == ST_SHIFT) begin
                r_acc <= w_accNext;
                if (w_done) begin
                    r_result <= w_accNext;
                    r_rdy    <= 1'b1;
                    r_exc    <= (r_op == OP_RSVD);
                end else begin
                    r_idx <= r_idx - IDX_W'(1);
                end
            end
        end
    end

    assign data_result    = r_result;
    assign data_resultRDY = r_rdy;
    assign data_exception = r_exc;
    assign busy           = (r_state == ST_SHIFT);

endmodule
